// File: rtl/obstacle_scheduler_if.sv
// Obstacle scheduler control and lane bus.
// Game controls in, per-lane positions and game status out.
interface obstacle_scheduler_if #(
  parameter int NUM_OBJ = 3,
  parameter int SCORE_W = 8
);
  logic                   start;
  logic                   pause;
  logic                   hit_in;
  logic [9*NUM_OBJ-1:0]   x_out;
  logic [8*NUM_OBJ-1:0]   y_out;
  logic [NUM_OBJ-1:0]     active;
  logic [SCORE_W-1:0]     score;
  logic [3:0]             level;
  logic [1:0]             misses;
  logic                   game_over;
  logic                   step;

  modport master (
    output start, pause, hit_in,
    input  x_out, y_out, active, score,
    input  level, misses, game_over, step
  );

  modport slave (
    input  start, pause, hit_in,
    output x_out, y_out, active, score,
    output level, misses, game_over, step
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Multi-lane obstacle mover with game FSM,
// speed-up, hit scoring and miss counting.
module obstacle_scheduler #(
  parameter int NUM_OBJ    = 3,
  parameter int CNT_W      = 24,
  parameter int DELAY_INIT = 5000000,
  parameter int DELAY_STEP = 500000,
  parameter int DELAY_MIN  = 500000,
  parameter int X_START    = 160,
  parameter int Y_BASE     = 40,
  parameter int Y_PITCH    = 40,
  parameter int SCORE_W    = 8,
  parameter int MAX_MISSES = 3
) (
  input  logic CLOCK_50,
  input  logic reset,
  obstacle_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_OVER
  } state_t;

  localparam logic [8:0]       XS     = 9'(X_START);
  localparam logic [CNT_W-1:0] D_INIT = CNT_W'(DELAY_INIT);
  localparam logic [CNT_W-1:0] D_STEP = CNT_W'(DELAY_STEP);
  localparam logic [CNT_W-1:0] D_MIN  = CNT_W'(DELAY_MIN);
  localparam logic [CNT_W:0]   D_THR  =
    (CNT_W+1)'(DELAY_MIN) + (CNT_W+1)'(DELAY_STEP);
  localparam logic [2:0]       MAXM   = 3'(MAX_MISSES);

  state_t               state_q, state_d;
  logic [8:0]           x_q [NUM_OBJ];
  logic [8:0]           x_d [NUM_OBJ];
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           level_q, level_d;
  logic [1:0]           miss_q, miss_d;
  logic [CNT_W-1:0]     cur_q, cur_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hit_q;

  logic [NUM_OBJ-1:0]   act;
  logic                 hit_rise;
  logic                 step_w;
  int                   tgt;
  logic [2:0]           wraps;
  logic [2:0]           msum;
  logic                 wrap0;

  assign hit_rise = bus.hit_in & ~hit_q;
  assign step_w   = (state_q == S_RUN) && (cnt_q == '0);

  // Lane i joins the game once level has reached i.
  always_comb begin
    act = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      act[i] = (state_q != S_IDLE) && (int'(level_q) >= i);
    end
  end

  // Respawn target: active lane nearest the left edge, lowest index wins ties.
  always_comb begin
    logic [8:0] best;
    logic       found;
    tgt   = 0;
    best  = '1;
    found = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (act[i] && (!found || x_q[i] < best)) begin
        found = 1'b1;
        best  = x_q[i];
        tgt   = i;
      end
    end
  end

  // Game FSM, lane motion, scoring and speed-up.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    level_d = level_q;
    miss_d  = miss_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    wraps   = '0;
    wrap0   = 1'b0;
    msum    = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      x_d[i] = x_q[i];
    end
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_d = S_RUN;
          score_d = '0;
          level_d = '0;
          miss_d  = '0;
          cur_d   = D_INIT;
          cnt_d   = D_INIT;
          for (int i = 0; i < NUM_OBJ; i++) begin
            x_d[i] = XS;
          end
        end
      end
      S_PAUSE: begin
        if (!bus.pause) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.pause) begin
          state_d = S_PAUSE;
        end else begin
          cnt_d = step_w ? cur_q : cnt_q - 1'b1;
          for (int i = 0; i < NUM_OBJ; i++) begin
            if (act[i]) begin
              if (hit_rise && i == tgt) begin
                x_d[i] = XS;
              end else if (step_w) begin
                if (x_q[i] == '0) begin
                  x_d[i] = XS;
                  wraps  = wraps + 3'd1;
                  if (i == 0) begin
                    wrap0 = 1'b1;
                  end
                end else begin
                  x_d[i] = x_q[i] - 9'd1;
                end
              end
            end
          end
          if (wrap0) begin
            cur_d = ({1'b0, cur_q} >= D_THR) ?
                    cur_q - D_STEP : D_MIN;
            if (level_q != 4'd15) begin
              level_d = level_q + 4'd1;
            end
          end
          msum = {1'b0, miss_q} + wraps;
          if (msum >= MAXM) begin
            miss_d  = MAXM[1:0];
            state_d = S_OVER;
          end else begin
            miss_d = msum[1:0];
          end
          if (hit_rise && score_q != '1) begin
            score_d = score_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State registers; hit_q samples hit_in every cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      score_q <= '0;
      level_q <= '0;
      miss_q  <= '0;
      cur_q   <= D_INIT;
      cnt_q   <= D_INIT;
      hit_q   <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i] <= XS;
      end
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      level_q <= level_d;
      miss_q  <= miss_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      hit_q   <= bus.hit_in;
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i] <= x_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_lane
    assign bus.x_out[9*g +: 9] = x_q[g];
    assign bus.y_out[8*g +: 8] = 8'(Y_BASE + g * Y_PITCH);
  end

  assign bus.active    = act;
  assign bus.score     = score_q;
  assign bus.level     = level_q;
  assign bus.misses    = miss_q;
  assign bus.game_over = (state_q == S_OVER);
  assign bus.step      = step_w;

endmodule
